// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states and
// the position of the opcode field inside ir_code.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_NOT  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_SAR  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;

  function automatic logic is_shift(input op_t op);
    case (op)
      OP_SHL, OP_SHR, OP_SAR: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: logic ops, ADD/SUB with carry and overflow.
// Shift opcodes pass B through so a shift by zero completes in one cycle.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  op_t              op_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;

  assign op_s   = op_t'(op);
  assign sum_s  = {1'b0, y} + {1'b0, b};
  assign diff_s = {1'b0, b} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};

  // Opcode decode into result and arithmetic flags
  always_comb begin
    result = {WIDTH{1'b0}};
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op_s)
      OP_ADD: begin
        result = sum_s[WIDTH-1:0];
        carry  = sum_s[WIDTH];
        ovf    = (y[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != y[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff_s[WIDTH-1:0];
        carry  = diff_s[WIDTH];
        ovf    = (b[WIDTH-1] != y[WIDTH-1]) && (diff_s[WIDTH-1] != b[WIDTH-1]);
      end
      OP_AND:                 result = y & b;
      OP_NOT:                 result = ~b;
      OP_OR:                  result = y | b;
      OP_XOR:                 result = y ^ b;
      OP_SHL, OP_SHR, OP_SAR: result = b;
      default:                result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready request in, registered result and flags out,
// with a one-bit-per-cycle shifter for shift opcodes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       ir_code,
  input  logic [WIDTH-1:0] reg_y_in,
  input  logic [WIDTH-1:0] bus_1_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag_out,
  output logic             carry_flag_out,
  output logic             neg_flag_out,
  output logic             ovf_flag_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_r;
  op_t              op_r;
  logic [WIDTH-1:0] shreg_r;
  logic [SHW-1:0]   cnt_r;

  op_t              op_s;
  logic [SHW-1:0]   amt_s;
  logic             accept_s;
  logic             go_shift_s;
  logic [WIDTH-1:0] core_res_s;
  logic             core_carry_s;
  logic             core_ovf_s;
  logic [WIDTH-1:0] step_s;
  logic             step_bit_s;
  logic             unused_s;

  assign op_s       = op_t'(ir_code[OPC_MSB:OPC_LSB]);
  assign amt_s      = reg_y_in[SHW-1:0];
  assign unused_s   = ^ir_code[OPC_LSB-1:0];
  assign in_ready   = (state_r == S_IDLE) || ((state_r == S_HOLD) && out_ready);
  assign accept_s   = in_valid && in_ready;
  assign go_shift_s = is_shift(op_s) && (amt_s != {SHW{1'b0}});

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op     (ir_code[OPC_MSB:OPC_LSB]),
    .y      (reg_y_in),
    .b      (bus_1_in),
    .result (core_res_s),
    .carry  (core_carry_s),
    .ovf    (core_ovf_s)
  );

  // One shifter step; step_bit_s is the bit that falls off the end
  always_comb begin
    step_s     = shreg_r;
    step_bit_s = 1'b0;
    case (op_r)
      OP_SHL: begin
        step_s     = {shreg_r[WIDTH-2:0], 1'b0};
        step_bit_s = shreg_r[WIDTH-1];
      end
      OP_SHR: begin
        step_s     = {1'b0, shreg_r[WIDTH-1:1]};
        step_bit_s = shreg_r[0];
      end
      OP_SAR: begin
        step_s     = {shreg_r[WIDTH-1], shreg_r[WIDTH-1:1]};
        step_bit_s = shreg_r[0];
      end
      default: begin
        step_s     = shreg_r;
        step_bit_s = 1'b0;
      end
    endcase
  end

  // Control FSM, shifter state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      op_r           <= OP_NONE;
      shreg_r        <= {WIDTH{1'b0}};
      cnt_r          <= {SHW{1'b0}};
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      alu_out        <= {WIDTH{1'b0}};
      zero_flag_out  <= 1'b0;
      carry_flag_out <= 1'b0;
      neg_flag_out   <= 1'b0;
      ovf_flag_out   <= 1'b0;
    end else begin
      case (state_r)
        S_SHIFT: begin
          shreg_r <= step_s;
          cnt_r   <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r        <= S_HOLD;
            busy           <= 1'b0;
            out_valid      <= 1'b1;
            alu_out        <= step_s;
            zero_flag_out  <= (step_s == {WIDTH{1'b0}});
            carry_flag_out <= step_bit_s;
            neg_flag_out   <= step_s[WIDTH-1];
            ovf_flag_out   <= 1'b0;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_IDLE, S_HOLD: begin
          if (accept_s && go_shift_s) begin
            state_r   <= S_SHIFT;
            op_r      <= op_s;
            shreg_r   <= bus_1_in;
            cnt_r     <= amt_s;
            busy      <= 1'b1;
            out_valid <= 1'b0;
          end else if (accept_s) begin
            state_r        <= S_HOLD;
            op_r           <= op_s;
            out_valid      <= 1'b1;
            alu_out        <= core_res_s;
            zero_flag_out  <= (core_res_s == {WIDTH{1'b0}});
            carry_flag_out <= core_carry_s;
            neg_flag_out   <= core_res_s[WIDTH-1];
            ovf_flag_out   <= core_ovf_s;
          end else if ((state_r == S_HOLD) && out_ready) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
